// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction memory.
// Holds the CPU off fetch (busy) while the stream is being consumed.
module imem_loader #(
  parameter int A_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               we,
  output logic [A_WIDTH-1:0] wa,
  output logic [7:0]         wd,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Largest image that fits; 17 bits so A_WIDTH=16 still compares correctly.
  localparam logic [16:0] MAX_N = 17'(2 ** A_WIDTH);

  logic [2:0]         state_q, state_d;
  logic [16:0]        cnt_q, cnt_d;
  logic [16:0]        len_q, len_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [7:0]         chk_q, chk_d;
  logic               we_q, we_d;
  logic [A_WIDTH-1:0] wa_q, wa_d;
  logic [7:0]         wd_q, wd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               loading;
  logic               xfer;
  logic [16:0]        len_n;
  logic [16:0]        cnt_inc;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.
  assign loading = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
  assign xfer    = in_valid && loading;
  assign len_n   = {1'b0, in_data, len_lo_q};
  assign cnt_inc = cnt_q + 17'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    len_lo_d = len_lo_q;
    chk_d    = chk_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          chk_d   = '0;
          len_d   = '0;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_n;
          cnt_d = '0;
          if (len_n == 17'd0) begin
            state_d = S_CHK;
          end else if (len_n > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          we_d  = 1'b1;
          wa_d  = cnt_q[A_WIDTH-1:0];
          wd_d  = in_data;
          chk_d = chk_q ^ in_data;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset aborts any load; memory contents already written are left as-is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      len_lo_q <= '0;
      chk_q    <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      len_lo_q <= len_lo_d;
      chk_q    <= chk_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in_ready    = loading;
  assign busy        = loading;
  assign we          = we_q;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes and outcomes
// come from the stream format itself (length prefix, payload, XOR byte).
module tb_imem_loader;

  localparam int A_WIDTH = 12;
  localparam int CAP     = 2 ** A_WIDTH;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               we;
  logic [A_WIDTH-1:0] wa;
  logic [7:0]         wd;
  logic               busy;
  logic               done;
  logic               err;
  logic [2:0]         dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int cycles  = 0;

  logic [7:0]  stim_q[$];
  logic [19:0] exp_q[$];

  imem_loader #(.A_WIDTH(A_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_wa"}, {{(32-A_WIDTH){1'b0}}, wa}, 32'd0);
    check({tag, "_wd"}, {24'd0, wd}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // Build a well-formed stream of n random payload bytes; corrupt the
  // checksum if bad_chk is set.
  task automatic build_stream(input int n, input bit bad_chk);
    logic [7:0] x;
    logic [7:0] b;
    stim_q.delete();
    stim_q.push_back(8'(n));
    stim_q.push_back(8'(n >> 8));
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      stim_q.push_back(b);
      x = x ^ b;
    end
    stim_q.push_back(bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_start_rdy"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_start_done"}, {31'd0, done}, 32'd0);
    check({tag, "_start_err"}, {31'd0, err}, 32'd0);
  endtask

  // Driver + scoreboard. mode 0: random in_valid at valid_pct; mode 1: toggle.
  // abort_at >= 0 asserts reset when that stream index is reached.
  // start_at >= 0 pulses start alongside that stream index.
  task automatic run_stream(input string tag, input int valid_pct, input bit toggle,
                            input int abort_at, input int start_at);
    int          n;
    int          last;
    int          idx;
    int          k;
    int          budget;
    bit          v;
    bit          exp_ok;
    bit          pend_we;
    logic [19:0] pend;
    logic [7:0]  x;

    n = int'(stim_q[0]) + (int'(stim_q[1]) << 8);
    // Oversized length: only the two length bytes are consumed.
    last = (n > CAP) ? 2 : n + 3;
    x = 8'h00;
    for (int i = 0; i < n && n <= CAP; i++) x = x ^ stim_q[i + 2];
    exp_ok = (n <= CAP) && (stim_q[n + 2] == x);
    exp_q.delete();

    idx = 0;
    k = 0;
    budget = cycles + 20000;
    pend_we = 1'b0;
    pend = '0;
    while (idx < last) begin
      if (cycles > budget) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs({tag, "_abort"});
        return;
      end
      check({tag, "_busy_in_load"}, {30'd0, busy, in_ready}, 32'd3);
      v = toggle ? (k % 2 == 0) : (32'($urandom_range(0, 99)) < 32'(valid_pct));
      k++;
      in_valid = v;
      start = (start_at >= 0 && idx == start_at);
      in_data = v ? stim_q[idx] : 8'($urandom_range(0, 255));
      pend_we = 1'b0;
      if (v) begin
        if (idx >= 2 && idx < n + 2 && n <= CAP) begin
          pend_we = 1'b1;
          pend = {12'(idx - 2), stim_q[idx]};
          exp_q.push_back(pend);
        end
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_we"}, {31'd0, we}, {31'd0, pend_we});
      if (pend_we) begin
        check({tag, "_wa_wd"}, {12'd0, wa, wd}, {12'd0, exp_q.pop_front()});
      end
    end
    in_valid = 1'b0;

    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_ok});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !exp_ok});
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdy_end"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);

    // Trailing bytes after completion must be refused.
    in_valid = 1'b1;
    in_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_no_trailing_we"}, {31'd0, we}, 32'd0);
    check({tag, "_sticky"}, {30'd0, done, err}, {30'd0, exp_ok, !exp_ok});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Bytes offered while idle are not accepted.
    in_valid = 1'b1;
    in_data = 8'h5a;
    @(negedge clk);
    in_valid = 1'b0;
    check_idle_outputs("idle_refuse");

    // Directed: 3-byte image 13 00 00.
    stim_q = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h13};
    do_start("three");
    run_stream("three", 100, 1'b0, -1, -1);

    // Zero-length image with good and bad checksum.
    stim_q = '{8'h00, 8'h00, 8'h00};
    do_start("zero_ok");
    run_stream("zero_ok", 100, 1'b0, -1, -1);
    stim_q = '{8'h00, 8'h00, 8'h01};
    do_start("zero_bad");
    run_stream("zero_bad", 100, 1'b0, -1, -1);

    // Length one beyond capacity.
    stim_q = '{8'h01, 8'h10, 8'hAA};
    do_start("ovf");
    run_stream("ovf", 100, 1'b0, -1, -1);

    // Toggling in_valid, N=4.
    build_stream(4, 1'b0);
    do_start("toggle");
    run_stream("toggle", 0, 1'b1, -1, -1);

    // Reset after 2 of 5 payload bytes, then a clean reload.
    build_stream(5, 1'b0);
    do_start("abort");
    run_stream("abort", 100, 1'b0, 4, -1);
    build_stream(5, 1'b0);
    do_start("reload");
    run_stream("reload", 70, 1'b0, -1, -1);

    // start mid-DATA is ignored.
    build_stream(8, 1'b0);
    do_start("midstart");
    run_stream("midstart", 100, 1'b0, -1, 5);

    // Full-capacity image exercises the top address.
    build_stream(CAP, 1'b0);
    do_start("full");
    run_stream("full", 100, 1'b0, -1, -1);

    // Randomized images, some with corrupted checksums.
    for (int t = 0; t < 12; t++) begin
      build_stream(int'($urandom_range(1, 40)), ($urandom_range(0, 3) == 0));
      do_start("rand");
      run_stream("rand", int'($urandom_range(30, 100)), 1'b0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
